// File: rtl/fetch_pc_unit.sv
// Fetch PC + IF/ID latch; FETCH_REDIRECT_HOLD_EN stores redirects seen during stall until release.
// Latency: imem_addr = pc combinationally; IF/ID loads one cycle after the address; one bubble per redirect.
// Backpressure: stall freezes pc and IF/ID; without the macro a redirect overrides stall.
module fetch_pc_unit #(
  parameter int                    PC_WIDTH = 11,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
  parameter logic [31:0]           NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc_next,
  output logic                if_id_valid,
  output logic                redirect_pending
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                take_redirect;
  logic [PC_WIDTH-1:0] redirect_target;

  // Wraps modulo 2^PC_WIDTH by construction.
  assign pc_inc    = pc + PC_WIDTH'(1);
  assign imem_addr = pc;

`ifdef FETCH_REDIRECT_HOLD_EN
  logic                pend_valid;
  logic [PC_WIDTH-1:0] pend_pc;

  // A live redirect on the release edge is newer than the stored one.
  assign take_redirect    = !stall && (redirect_valid || pend_valid);
  assign redirect_target  = redirect_valid ? redirect_pc : pend_pc;
  assign redirect_pending = pend_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_pc    <= RESET_PC;
    end else if (stall) begin
      if (redirect_valid) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
    end else begin
      pend_valid <= 1'b0;
    end
  end
`else
  assign take_redirect    = redirect_valid;
  assign redirect_target  = redirect_pc;
  assign redirect_pending = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      if_id_instr   <= NOP_WORD;
      if_id_pc_next <= RESET_PC;
      if_id_valid   <= 1'b0;
    end else if (take_redirect) begin
      // Wrong-path word fetched this cycle is dropped as a bubble.
      pc            <= redirect_target;
      if_id_instr   <= NOP_WORD;
      if_id_pc_next <= redirect_target;
      if_id_valid   <= 1'b0;
    end else if (!stall) begin
      pc            <= pc_inc;
      if_id_instr   <= imem_data;
      if_id_pc_next <= pc_inc;
      if_id_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus random stall/redirect/reset traffic.
module tb_fetch_pc_unit;

  localparam int PCW  = 11;
  localparam int NPC  = 2048;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            redirect_valid;
  logic [PCW-1:0]  redirect_pc;
  logic [PCW-1:0]  imem_addr;
  logic [31:0]     imem_data;
  logic [31:0]     if_id_instr;
  logic [PCW-1:0]  if_id_pc_next;
  logic            if_id_valid;
  logic            redirect_pending;

  logic [31:0] mem [NPC];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, kept as plain integers.
  int          m_pc, m_pc_next, m_pend_pc;
  logic [31:0] m_instr;
  bit          m_valid, m_pend;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .if_id_instr      (if_id_instr),
    .if_id_pc_next    (if_id_pc_next),
    .if_id_valid      (if_id_valid),
    .redirect_pending (redirect_pending)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit rv, input int t);
    bit hold_en;
    bit take;
    int tgt;
`ifdef FETCH_REDIRECT_HOLD_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    if (r) begin
      m_pc = 0; m_instr = NOP; m_pc_next = 0; m_valid = 0; m_pend = 0; m_pend_pc = 0;
      return;
    end
    if (hold_en) begin
      take = !s && (rv || m_pend);
      tgt  = rv ? t : m_pend_pc;
      if (s && rv) begin
        m_pend = 1; m_pend_pc = t;
      end
      if (!s) m_pend = 0;
    end else begin
      take = rv;
      tgt  = t;
    end
    if (take) begin
      m_pc = tgt; m_instr = NOP; m_pc_next = tgt; m_valid = 0;
    end else if (!s) begin
      m_instr   = mem[m_pc];
      m_pc      = (m_pc + 1) % NPC;
      m_pc_next = m_pc;
      m_valid   = 1;
    end
  endtask

  // Drive one cycle's inputs, clock it, then compare everything with the model.
  task automatic cycle(input bit r, input bit s, input bit rv, input int t);
    reset = r; stall = s; redirect_valid = rv; redirect_pc = PCW'(t);
    @(posedge clk);
    model_edge(r, s, rv, t);
    #1;
    check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
    check_eq("if_id_instr", if_id_instr, m_instr);
    check_eq("if_id_pc_next", 32'(if_id_pc_next), 32'(m_pc_next));
    check_eq("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    check_eq("redirect_pending", 32'(redirect_pending), 32'(m_pend));
  endtask

  initial begin
    for (int i = 0; i < NPC; i++) mem[i] = $urandom;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_pc = 0; m_pc_next = 0; m_pend_pc = 0; m_instr = NOP; m_valid = 0; m_pend = 0;

    // Reset state.
    cycle(1, 0, 0, 0);
    check_eq("rst_addr", 32'(imem_addr), 0);
    check_eq("rst_valid", 32'(if_id_valid), 0);
    check_eq("rst_instr", if_id_instr, NOP);

    // Free run from reset.
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 0, 0, 0);
      check_eq("run_addr", 32'(imem_addr), 32'(i));
      check_eq("run_instr", if_id_instr, mem[i-1]);
      check_eq("run_pc_next", 32'(if_id_pc_next), 32'(i));
    end

    // Wrap around the top of the address space.
    cycle(0, 0, 1, 2046);
    check_eq("wrap_addr0", 32'(imem_addr), 2046);
    cycle(0, 0, 0, 0);
    check_eq("wrap_addr1", 32'(imem_addr), 2047);
    cycle(0, 0, 0, 0);
    check_eq("wrap_addr2", 32'(imem_addr), 0);
    check_eq("wrap_pc_next", 32'(if_id_pc_next), 0);
    check_eq("wrap_instr", if_id_instr, mem[2047]);

    // Redirect to 100 from pc 7.
    cycle(0, 0, 1, 7);
    cycle(0, 0, 1, 100);
    check_eq("redir_addr", 32'(imem_addr), 100);
    check_eq("redir_bubble", 32'(if_id_valid), 0);
    cycle(0, 0, 0, 0);
    check_eq("redir_instr", if_id_instr, mem[100]);
    check_eq("redir_pc_next", 32'(if_id_pc_next), 101);
    check_eq("redir_valid", 32'(if_id_valid), 1);

    // Stall three cycles at pc 20.
    cycle(0, 0, 1, 17);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      check_eq("stall_addr", 32'(imem_addr), 20);
      check_eq("stall_instr", if_id_instr, mem[19]);
    end
    cycle(0, 0, 0, 0);
    check_eq("stall_release", 32'(imem_addr), 21);

    // Redirects arriving during a stall.
    cycle(0, 1, 1, 300);
`ifdef FETCH_REDIRECT_HOLD_EN
    check_eq("hold_addr", 32'(imem_addr), 21);
    check_eq("hold_pending", 32'(redirect_pending), 1);
`else
    check_eq("ovr_addr300", 32'(imem_addr), 300);
`endif
    cycle(0, 1, 1, 400);
`ifndef FETCH_REDIRECT_HOLD_EN
    check_eq("ovr_addr400", 32'(imem_addr), 400);
`endif
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
`ifdef FETCH_REDIRECT_HOLD_EN
    check_eq("hold_apply", 32'(imem_addr), 400);
    check_eq("hold_bubble", 32'(if_id_valid), 0);
    check_eq("hold_cleared", 32'(redirect_pending), 0);

    // Reset discards a stored redirect.
    cycle(0, 1, 1, 500);
    check_eq("rp_pending", 32'(redirect_pending), 1);
    cycle(1, 1, 0, 0);
    check_eq("rp_addr", 32'(imem_addr), 0);
    check_eq("rp_cleared", 32'(redirect_pending), 0);
    cycle(0, 0, 0, 0);
    check_eq("rp_no_stale", 32'(imem_addr), 1);
`else
    check_eq("ovr_step", 32'(imem_addr), 401);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 15), int'($urandom_range(0, NPC - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage program counter and IF/ID pipeline latch. It is the consumer of the branch-target adder's 11-bit `new_pc`. It holds the current PC, drives the instruction-memory address, and steps the PC by one word per cycle. On a redirect it loads the redirect target and turns the wrong-path fetch into a bubble. A stall from the hazard unit freezes the block.

## Interface
Parameters:
- PC_WIDTH, 11, width of PC and instruction-memory address
- RESET_PC, 11'd0, PC value loaded on reset
- NOP_WORD, 32'h0000_0000, instruction word inserted for bubbles

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents
- redirect_valid  in  1  taken branch/jump resolved this cycle
- redirect_pc  in  PC_WIDTH  target PC (adder `new_pc`)
- imem_addr  out  PC_WIDTH  instruction-memory address, equals current PC
- imem_data  in  32  instruction word, combinational read of imem_addr
- if_id_instr  out  32  latched instruction
- if_id_pc_next  out  PC_WIDTH  latched PC+1 of that instruction (old_pc input for the adder)
- if_id_valid  out  1  latched instruction is real, not a bubble
- redirect_pending  out  1  a redirect is stored awaiting stall release

## Operation
- State registers: pc, if_id_instr, if_id_pc_next, if_id_valid, and pend_valid/pend_pc (only with the macro).
- imem_addr = pc, combinational.
- Next PC is pc + 1, computed modulo 2^PC_WIDTH: 2047 + 1 = 0, no error flag.
- redirect_pc is taken as-is and is never re-added or truncated.
- Per-cycle priority: reset > redirect (per Configuration) > stall > normal step.
- Normal step (no stall, no redirect):
  - pc <= pc+1
  - if_id_instr <= imem_data
  - if_id_pc_next <= pc+1
  - if_id_valid <= 1
- Redirect accepted:
  - pc <= target
  - if_id_instr <= NOP_WORD
  - if_id_pc_next <= target
  - if_id_valid <= 0, so the fetched word is discarded
- Stall with no accepted redirect: all registers hold.
- Reset: pc = RESET_PC, if_id_instr = NOP_WORD, if_id_pc_next = RESET_PC, if_id_valid = 0, pend_valid = 0, redirect_pending = 0. Any pending redirect is discarded.

## Timing
- Latency:
  - imem_addr tracks pc combinationally.
  - An instruction appears on if_id_* one cycle after its address is presented.
  - A redirect sampled at edge N gives imem_addr = target after N.
  - The first valid target instruction is in IF/ID after edge N+1.
  - Exactly one bubble per redirect.
- stall and redirect_valid are sampled on the same edge. Their interaction is defined in Configuration.
- Back-to-back redirects: each is accepted and the latest target wins. IF/ID stays a bubble for every redirect cycle.
- Reset asserted mid-stall or mid-pending: outputs take reset values at the next edge. Inputs in the reset cycle are ignored.
- When reset deasserts, the first fetch of RESET_PC occurs on that edge's following cycle.

## Configuration
- FETCH_REDIRECT_HOLD_EN defined:
  - A redirect during stall is stored: pend_valid <= 1, pend_pc <= redirect_pc. PC and IF/ID hold, and redirect_pending = 1.
  - A newer redirect while pending overwrites pend_pc.
  - On the first edge with stall = 0, the redirect is applied using pend_pc, or redirect_valid's target if also asserted that cycle (latest wins), and pend_valid clears.
- FETCH_REDIRECT_HOLD_EN undefined:
  - Redirect overrides stall and is applied immediately, even with stall = 1.
  - redirect_pending is tied to 0 and there are no pending registers.

## Test plan
- Reset, then 5 free-running cycles: imem_addr goes 0,1,2,3,4. Each if_id_instr equals the word at the prior address, if_id_pc_next = address + 1, and if_id_valid = 1 from the second cycle.
- Wrap: force pc to 2046 via redirect, then run 3 cycles. imem_addr goes 2046, 2047, 0 and if_id_pc_next for address 2047 is 0.
- Redirect to 100 at pc = 7:
  - Next imem_addr = 100 and IF/ID = NOP_WORD, valid 0.
  - Following cycle: IF/ID holds the word from address 100, pc_next 101, valid 1.
- Stall 3 cycles at pc = 20: imem_addr stays 20 and all if_id_* are unchanged. After release, pc steps to 21.
- Redirect to 300 in the first stall cycle, then 400 in the second, with stall = 1 for 3 cycles:
  - Macro on: redirect_pending = 1 and pc stays. On release, pc = 400 with one bubble.
  - Macro off: pc = 300 then 400 immediately.
- Assert reset while redirect_pending = 1 (macro on): next cycle pc = RESET_PC, valid 0, redirect_pending 0. Release stall: no stale redirect is applied.
